// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp + prescaler) on the data bus.
// Optional MMIO_TIMER_READ_LATCH_EN: MTIME_LO reads latch mtime[63:32] for coherent HI reads.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [3:0]  dmem_write_mask_i,
  input  logic [31:0] dmem_write_data_i,
  output logic [31:0] dmem_read_data_o,
  output logic        irq_o
);

  localparam logic [3:0] OFS_MTIME_LO = 4'd0;
  localparam logic [3:0] OFS_MTIME_HI = 4'd1;
  localparam logic [3:0] OFS_CMP_LO   = 4'd2;
  localparam logic [3:0] OFS_CMP_HI   = 4'd3;
  localparam logic [3:0] OFS_CTRL     = 4'd4;
  localparam logic [3:0] OFS_PRESCALE = 4'd5;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pc;
  logic [31:0]           r_rdata;
  logic                  r_irq;
`ifdef MMIO_TIMER_READ_LATCH_EN
  logic [31:0]           r_shadow;
`endif

  logic                  w_in_win;
  logic [3:0]            w_ofs;
  logic                  w_wr;
  logic                  w_tick;
  logic [63:0]           w_mtime_inc;
  logic [63:0]           w_mtime_nxt;
  logic [63:0]           w_cmp_nxt;
  logic                  w_en_nxt;
  logic [31:0]           w_pre32;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic [PRESCALE_W-1:0] w_pc_nxt;
  logic [31:0]           w_rdata_nxt;
  logic                  w_unused;

  // Replace only the byte lanes enabled in the write mask.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_unused = ^dmem_addr_i[1:0];

  // Decode, prescaler, register update and read mux.
  always_comb begin
    w_in_win    = (dmem_addr_i[31:6] == BASE_ADDR[31:6]);
    w_ofs       = dmem_addr_i[5:2];
    w_wr        = w_in_win && (dmem_write_mask_i != 4'b0000);
    w_tick      = r_en && (r_pc == r_prescale);
    w_mtime_inc = r_mtime + 64'(w_tick);
    w_mtime_nxt = w_mtime_inc;
    w_cmp_nxt   = r_mtimecmp;
    w_en_nxt    = r_en;
    w_pre32     = merge_lanes(32'(r_prescale), dmem_write_data_i, dmem_write_mask_i);
    w_prescale_nxt = r_prescale;
    w_pc_nxt    = r_pc;
    w_rdata_nxt = 32'h0;

    if (r_en) w_pc_nxt = w_tick ? '0 : r_pc + PRESCALE_W'(1);

    if (w_wr) begin
      case (w_ofs)
        OFS_MTIME_LO: w_mtime_nxt[31:0]  = merge_lanes(w_mtime_inc[31:0], dmem_write_data_i, dmem_write_mask_i);
        OFS_MTIME_HI: w_mtime_nxt[63:32] = merge_lanes(w_mtime_inc[63:32], dmem_write_data_i, dmem_write_mask_i);
        OFS_CMP_LO:   w_cmp_nxt[31:0]    = merge_lanes(r_mtimecmp[31:0], dmem_write_data_i, dmem_write_mask_i);
        OFS_CMP_HI:   w_cmp_nxt[63:32]   = merge_lanes(r_mtimecmp[63:32], dmem_write_data_i, dmem_write_mask_i);
        OFS_CTRL:     if (dmem_write_mask_i[0]) w_en_nxt = dmem_write_data_i[0];
        OFS_PRESCALE: begin
          w_prescale_nxt = PRESCALE_W'(w_pre32);
          w_pc_nxt       = '0;
        end
        default: ;
      endcase
    end

    if (w_in_win) begin
      case (w_ofs)
        OFS_MTIME_LO: w_rdata_nxt = r_mtime[31:0];
`ifdef MMIO_TIMER_READ_LATCH_EN
        OFS_MTIME_HI: w_rdata_nxt = r_shadow;
`else
        OFS_MTIME_HI: w_rdata_nxt = r_mtime[63:32];
`endif
        OFS_CMP_LO:   w_rdata_nxt = r_mtimecmp[31:0];
        OFS_CMP_HI:   w_rdata_nxt = r_mtimecmp[63:32];
        OFS_CTRL:     w_rdata_nxt = {31'h0, r_en};
        OFS_PRESCALE: w_rdata_nxt = 32'(r_prescale);
        default:      w_rdata_nxt = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mtime    <= 64'h0;
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_en       <= 1'b0;
      r_prescale <= '0;
      r_pc       <= '0;
      r_rdata    <= 32'h0;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_en       <= w_en_nxt;
      r_prescale <= w_prescale_nxt;
      r_pc       <= w_pc_nxt;
      r_rdata    <= w_rdata_nxt;
      r_irq      <= r_en && (r_mtime >= r_mtimecmp);
    end
  end

`ifdef MMIO_TIMER_READ_LATCH_EN
  // Snapshot the high word whenever the low word is read.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_shadow <= 32'h0;
    end else if (w_in_win && (w_ofs == OFS_MTIME_LO)) begin
      r_shadow <= r_mtime[63:32];
    end
  end
`endif

  assign dmem_read_data_o = r_rdata;
  assign irq_o            = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus random bus traffic vs. a reference model.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk_i;
  logic        reset_n_i;
  logic [31:0] dmem_addr_i;
  logic [3:0]  dmem_write_mask_i;
  logic [31:0] dmem_write_data_i;
  logic [31:0] dmem_read_data_o;
  logic        irq_o;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: timer value, compare, enable, prescale and enabled-cycle count.
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [15:0] m_pre;
  int          m_since;
  logic [31:0] m_shadow;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .dmem_addr_i       (dmem_addr_i),
    .dmem_write_mask_i (dmem_write_mask_i),
    .dmem_write_data_i (dmem_write_data_i),
    .dmem_read_data_o  (dmem_read_data_o),
    .irq_o             (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] ofs);
    case (ofs)
      4'd0: return m_mtime[31:0];
`ifdef MMIO_TIMER_READ_LATCH_EN
      4'd1: return m_shadow;
`else
      4'd1: return m_mtime[63:32];
`endif
      4'd2: return m_cmp[31:0];
      4'd3: return m_cmp[63:32];
      4'd4: return {31'h0, m_en};
      4'd5: return {16'h0, m_pre};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime  = 64'h0;
    m_cmp    = '1;
    m_en     = 1'b0;
    m_pre    = 16'h0;
    m_since  = 0;
    m_shadow = 32'h0;
  endtask

  // One bus cycle: drive, predict, then compare registered outputs after the edge.
  task automatic cycle(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    logic        inwin;
    logic [3:0]  ofs;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic        tick;
    logic [63:0] nt;
    @(negedge clk_i);
    dmem_addr_i       = a;
    dmem_write_mask_i = m;
    dmem_write_data_i = d;
    inwin   = (a[31:6] == BASE[31:6]);
    ofs     = a[5:2];
    exp_rd  = inwin ? model_read(ofs) : 32'h0;
    exp_irq = m_en && (m_mtime >= m_cmp);
    tick    = m_en && ((m_since % (int'(m_pre) + 1)) == int'(m_pre));
    nt      = m_mtime + (tick ? 64'd1 : 64'd0);
    if (inwin && ofs == 4'd0) m_shadow = m_mtime[63:32];
    if (m_en) m_since++;
    if (inwin && m != 4'b0) begin
      case (ofs)
        4'd0: nt[31:0]  = lanes(nt[31:0], d, m);
        4'd1: nt[63:32] = lanes(nt[63:32], d, m);
        4'd2: m_cmp[31:0]  = lanes(m_cmp[31:0], d, m);
        4'd3: m_cmp[63:32] = lanes(m_cmp[63:32], d, m);
        4'd4: if (m[0]) m_en = d[0];
        4'd5: begin
          m_pre   = lanes({16'h0, m_pre}, d, m) & 32'h0000_FFFF;
          m_since = 0;
        end
        default: ;
      endcase
    end
    m_mtime = nt;
    @(posedge clk_i);
    #1;
    check("rdata", 64'(dmem_read_data_o), 64'(exp_rd));
    check("irq", 64'(irq_o), 64'(exp_irq));
  endtask

  task automatic wr(input logic [3:0] ofs, input logic [31:0] d);
    cycle(BASE | 32'({ofs, 2'b00}), 4'hF, d);
  endtask

  task automatic rd(input logic [3:0] ofs);
    cycle(BASE | 32'({ofs, 2'b00}), 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    logic [3:0]  ofs;
    reset_n_i = 1'b0;
    dmem_addr_i = 32'h0;
    dmem_write_mask_i = 4'h0;
    dmem_write_data_i = 32'h0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rdata", 64'(dmem_read_data_o), 64'h0);
    check("rst_irq", 64'(irq_o), 64'h0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Reset values of every offset, unmapped offset and out-of-window address.
    for (int i = 0; i < 7; i++) rd(4'(i));
    rd(4'd2);
    check("rst_cmp_lo", 64'(dmem_read_data_o), 64'hFFFF_FFFF);
    cycle(32'h0000_0000, 4'h0, 32'h0);
    check("out_of_window", 64'(dmem_read_data_o), 64'h0);

    // Prescale 3: one tick per 4 enabled cycles, then freeze.
    wr(4'd5, 32'd3);
    wr(4'd4, 32'd1);
    repeat (20) rd(4'd0);
    wr(4'd4, 32'd0);
    rd(4'd0);
    check("presc_cnt", 64'(dmem_read_data_o), 64'd5);
    repeat (3) rd(4'd0);
    check("frozen", 64'(dmem_read_data_o), 64'd5);

    // Compare at 10, then raise compare to drop irq.
    wr(4'd0, 32'd0);
    wr(4'd1, 32'd0);
    wr(4'd5, 32'd0);
    wr(4'd2, 32'd10);
    wr(4'd3, 32'd0);
    wr(4'd4, 32'd1);
    repeat (14) rd(4'd0);
    check("irq_high", 64'(irq_o), 64'd1);
    wr(4'd2, 32'd100);
    rd(4'd0);
    check("irq_cleared", 64'(irq_o), 64'd0);

    // Write to MTIME_LO on a tick cycle: write wins.
    wr(4'd0, 32'h1234);
    rd(4'd0);
    check("write_wins", 64'(dmem_read_data_o), 64'h1234);

    // Carry lo -> hi while reading lo then hi.
    wr(4'd4, 32'd0);
    wr(4'd0, 32'hFFFF_FFFF);
    wr(4'd1, 32'd0);
    wr(4'd4, 32'd1);
    rd(4'd0);
    rd(4'd1);
`ifdef MMIO_TIMER_READ_LATCH_EN
    check("hi_after_carry", 64'(dmem_read_data_o), 64'd0);
`else
    check("hi_after_carry", 64'(dmem_read_data_o), 64'd1);
`endif

    // Full 64-bit wrap.
    wr(4'd4, 32'd0);
    wr(4'd0, 32'hFFFF_FFFF);
    wr(4'd1, 32'hFFFF_FFFF);
    wr(4'd4, 32'd1);
    rd(4'd0);
    rd(4'd0);
    check("wrap_lo", 64'(dmem_read_data_o), 64'h0);
    rd(4'd1);
    wr(4'd4, 32'd0);

    // Single byte-lane write.
    wr(4'd2, 32'h0);
    cycle(BASE | 32'h8, 4'b0010, 32'h1234_AB56);
    rd(4'd2);
    check("byte_lane", 64'(dmem_read_data_o), 64'h0000_AB00);

    // Async reset mid-count with irq asserted.
    wr(4'd2, 32'd0);
    wr(4'd3, 32'd0);
    wr(4'd4, 32'd1);
    repeat (5) rd(4'd0);
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_rst_irq", 64'(irq_o), 64'h0);
    check("async_rst_rdata", 64'(dmem_read_data_o), 64'h0);
    model_reset();
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 6; i++) rd(4'(i));
    repeat (3) rd(4'd0);

    // Random bus traffic.
    for (int n = 0; n < 600; n++) begin
      ofs = 4'($urandom_range(0, 7));
      m   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d   = $urandom;
      if (ofs == 4'd5) d = $urandom_range(0, 3);
      if (ofs == 4'd1 || ofs == 4'd3) d = $urandom_range(0, 2);
      a = BASE | 32'({ofs, 2'b00});
      if ($urandom_range(0, 9) == 0) a = 32'h1000_0000 | ($urandom & 32'h0000_FFFF);
      cycle(a, m, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
